// File: rtl/clock_time_counter_if.sv
// Bundles the edit buttons and the six BCD digit outputs shared between
// the time counter and whatever drives or watches it.
interface clock_time_counter_if;
    logic       i_mode;
    logic       i_inc;
    logic       i_dec;
    logic [3:0] o_hour_h;
    logic [3:0] o_hour_l;
    logic [3:0] o_minute_h;
    logic [3:0] o_minute_l;
    logic [3:0] o_second_h;
    logic [3:0] o_second_l;
    logic [1:0] o_mode;
    logic       o_sec_pulse;

    modport master (
        output i_mode, i_inc, i_dec,
        input  o_hour_h, o_hour_l, o_minute_h, o_minute_l,
        input  o_second_h, o_second_l, o_mode, o_sec_pulse
    );

    modport slave (
        input  i_mode, i_inc, i_dec,
        output o_hour_h, o_hour_l, o_minute_h, o_minute_l,
        output o_second_h, o_second_l, o_mode, o_sec_pulse
    );
endinterface

// File: rtl/clock_time_counter.sv
// BCD hh:mm:ss time-of-day counter with a 1 Hz prescaler and a small
// set-mode FSM for adjusting each field with single-cycle button pulses.
module clock_time_counter #(
    parameter int TICK_DIV = 50000000
) (
    input  logic                 i_clk,
    input  logic                 r_rst,
    clock_time_counter_if.slave  bus
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } modeT;

    modeT          mode_q, mode_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    hour_q, hour_d;
    logic [7:0]    minute_q, minute_d;
    logic [7:0]    second_q, second_d;
    logic          secPulse_q, secPulse_d;
    logic          tick;
    logic          editInc;
    logic          editDec;

    // Two-digit BCD field helpers; wrap within the field with no carry out.
    function automatic logic [7:0] bcdInc(input logic [7:0] v, input logic [7:0] maxV);
        if (v == maxV)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcdDec(input logic [7:0] v, input logic [7:0] maxV);
        if (v == 8'h00)
            return maxV;
        else if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    assign tick    = (mode_q == RUN) && (presc_q == PRESC_LAST);
    assign editInc = bus.i_inc && !bus.i_dec && !bus.i_mode;
    assign editDec = bus.i_dec && !bus.i_inc && !bus.i_mode;

    always_ff @(posedge i_clk or posedge r_rst) begin
        if (r_rst) begin
            mode_q     <= RUN;
            presc_q    <= '0;
            hour_q     <= 8'h00;
            minute_q   <= 8'h00;
            second_q   <= 8'h00;
            secPulse_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            presc_q    <= presc_d;
            hour_q     <= hour_d;
            minute_q   <= minute_d;
            second_q   <= second_d;
            secPulse_q <= secPulse_d;
        end
    end

    always_comb begin
        mode_d     = mode_q;
        hour_d     = hour_q;
        minute_d   = minute_q;
        second_d   = second_q;
        secPulse_d = tick;
        presc_d    = ((mode_q == RUN) && !tick) ? presc_q + PW'(1) : '0;

        if (tick) begin
            second_d = bcdInc(second_q, 8'h59);
            if (second_q == 8'h59) begin
                minute_d = bcdInc(minute_q, 8'h59);
                if (minute_q == 8'h59)
                    hour_d = bcdInc(hour_q, 8'h23);
            end
        end

        // A mode pulse takes priority and swallows any edit in the same cycle.
        if (bus.i_mode) begin
            case (mode_q)
                RUN:      mode_d = SET_HOUR;
                SET_HOUR: mode_d = SET_MIN;
                SET_MIN:  mode_d = SET_SEC;
                default:  mode_d = RUN;
            endcase
        end else begin
            case (mode_q)
                SET_HOUR: begin
                    if (editInc) hour_d = bcdInc(hour_q, 8'h23);
                    if (editDec) hour_d = bcdDec(hour_q, 8'h23);
                end
                SET_MIN: begin
                    if (editInc) minute_d = bcdInc(minute_q, 8'h59);
                    if (editDec) minute_d = bcdDec(minute_q, 8'h59);
                end
                SET_SEC: begin
                    if (editInc) second_d = bcdInc(second_q, 8'h59);
                    if (editDec) second_d = bcdDec(second_q, 8'h59);
                end
                default: ;
            endcase
        end
    end

    assign bus.o_hour_h    = hour_q[7:4];
    assign bus.o_hour_l    = hour_q[3:0];
    assign bus.o_minute_h  = minute_q[7:4];
    assign bus.o_minute_l  = minute_q[3:0];
    assign bus.o_second_h  = second_q[7:4];
    assign bus.o_second_l  = second_q[3:0];
    assign bus.o_mode      = mode_q;
    assign bus.o_sec_pulse = secPulse_q;
endmodule
